// File: rtl/ahb_pkg.sv
// Shared AHB-Lite / bridge definitions: transfer encodings, response codes,
// bridge FSM state encodings and the largest legal transfer size.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Widest transfer the APB segment can carry (word).
  localparam logic [2:0] HSIZE_MAX = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_t;

endpackage

// File: rtl/bridge_timeout_cnt.sv
// ACCESS-phase watchdog for the AHB-to-APB bridge. Cleared by load, advances
// on count, and flags expire in the count cycle that completes TIMEOUT_CYC.
module bridge_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_reg;

  // Cycle counter: restart on load, advance while the peripheral stalls.
  always_ff @(posedge clk) begin
    if (srst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (count && cnt_reg != CNT_LAST) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expire = count && (cnt_reg == CNT_LAST);

endmodule

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite responder that converts each selected AHB beat into one APB3
// transfer. All outputs are registered. hresetn is a synchronous active-high
// reset despite its name. Optional ACCESS-phase timeout: define APB_TIMEOUT_EN.
module ahb_apb_bridge
  import ahb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              hsel,
  input  logic              hready,
  input  logic [1:0]        htrans,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic              hresp,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  bridge_state_t state_reg, state_next;

  logic accept;
  logic can_accept;
  logic timeout_expire;
  logic hreadyout_next;
  logic hresp_next;
  logic psel_next;
  logic penable_next;

  // Bursts are split into independent beats and IDLE/BUSY are treated alike.
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};

  assign can_accept = (state_reg == ST_IDLE) || (state_reg == ST_ERR2);
  assign accept     = can_accept && hsel && hready && htrans[1];

`ifdef APB_TIMEOUT_EN
  bridge_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (hclk),
    .srst   (hresetn),
    .load   (state_reg == ST_SETUP),
    .count  ((state_reg == ST_ACCESS) && !pready),
    .expire (timeout_expire)
  );
`else
  assign timeout_expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE, ST_ERR2: begin
        if (accept) begin
          if (hsize > HSIZE_MAX) begin
            state_next = ST_ERR1;
          end else if (hwrite) begin
            state_next = ST_WDATA;
          end else begin
            state_next = ST_SETUP;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_WDATA:  state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: begin
        if (pready) begin
          state_next = pslverr ? ST_ERR1 : ST_IDLE;
        end else if (timeout_expire) begin
          state_next = ST_ERR1;
        end
      end
      ST_ERR1:   state_next = ST_ERR2;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the registered outputs line up
  // with the state they describe.
  always_comb begin
    hreadyout_next = 1'b1;
    hresp_next     = HRESP_OKAY;
    psel_next      = 1'b0;
    penable_next   = 1'b0;
    case (state_next)
      ST_WDATA:  hreadyout_next = 1'b0;
      ST_SETUP: begin
        hreadyout_next = 1'b0;
        psel_next      = 1'b1;
      end
      ST_ACCESS: begin
        hreadyout_next = 1'b0;
        psel_next      = 1'b1;
        penable_next   = 1'b1;
      end
      ST_ERR1: begin
        hreadyout_next = 1'b0;
        hresp_next     = HRESP_ERROR;
      end
      ST_ERR2:   hresp_next = HRESP_ERROR;
      default:   ;
    endcase
  end

  // Output registers: handshake, address/direction capture, data paths.
  always_ff @(posedge hclk) begin
    if (hresetn) begin
      hreadyout <= 1'b1;
      hresp     <= HRESP_OKAY;
      hrdata    <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      hreadyout <= hreadyout_next;
      hresp     <= hresp_next;
      psel      <= psel_next;
      penable   <= penable_next;
      if (accept) begin
        paddr  <= haddr;
        pwrite <= hwrite;
      end
      // hwdata belongs to the data phase, which is the WDATA cycle.
      if (state_reg == ST_WDATA) begin
        pwdata <= hwdata;
      end
      if (state_reg == ST_ACCESS && pready && !pslverr && !pwrite) begin
        hrdata <= prdata;
      end
    end
  end

endmodule
